// File: rtl/dmem_sram_like_bridge_pkg.sv
// Shared types and constants for the data-memory SRAM-like bridge.
//   - bridge_state_e : transaction FSM encoding (IDLE, ADDR, DATA, DONE)
//   - SZ_*           : sram-like bus size codes
package dmem_sram_like_bridge_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StAddr = 2'd1,
      StData = 2'd2,
      StDone = 2'd3
   } bridge_state_e;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/dmem_sram_like_bridge_wen_to_size.sv
// Maps a 4-bit byte write-enable onto the sram-like bus size code.
// Ports:
//   wen_i  : byte write enables (non-zero for a store)
//   size_o : bus size (1111 -> word, 0011/1100 -> half, one-hot -> byte)
module dmem_sram_like_bridge_wen_to_size
   import dmem_sram_like_bridge_pkg::*;
(
   input  logic [3:0] wen_i,
   output logic [1:0] size_o
);

   always_comb begin
      size_o = SZ_WORD;
      case (wen_i)
         4'b1111:                            size_o = SZ_WORD;
         4'b0011, 4'b1100:                   size_o = SZ_HALF;
         4'b0001, 4'b0010, 4'b0100, 4'b1000: size_o = SZ_BYTE;
         // Illegal lane patterns are filtered upstream; fall back to a word.
         default:                            size_o = SZ_WORD;
      endcase
   end

endmodule

// File: rtl/dmem_sram_like_bridge.sv
// Bridge from the memory stage's single-cycle SRAM-style request to the
// handshaked sram-like bus (req / addr_ok / data_ok). Stalls the pipeline
// until the access completes and holds the load data while it stays stalled.
//
// Optional feature (macro DMEM_BRIDGE_RDATA_BYPASS_EN): forward data_rdata to
// cpu_rdata in the data_ok cycle, drop mem_stall there, and skip DONE when the
// pipeline is free to advance.
//
// Ports:
//   clk, resetn              : clock, asynchronous active-low reset
//   cpu_mem_en/wen/size/addr/wdata : memory-stage request
//   cpu_rdata                : load data back to the memory stage
//   cpu_longest_stall        : OR of all pipeline stalls (including ours)
//   mem_stall                : stall request to the hazard unit
//   data_req/wr/size/addr/wdata    : sram-like bus request
//   data_addr_ok/data_ok/rdata     : sram-like bus responses
module dmem_sram_like_bridge
   import dmem_sram_like_bridge_pkg::*;
#(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              cpu_mem_en,
   input  logic [3:0]        cpu_wen,
   input  logic [1:0]        cpu_size,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   input  logic              cpu_longest_stall,
   output logic              mem_stall,
   output logic              data_req,
   output logic              data_wr,
   output logic [1:0]        data_size,
   output logic [ADDR_W-1:0] data_addr,
   output logic [DATA_W-1:0] data_wdata,
   input  logic              data_addr_ok,
   input  logic              data_data_ok,
   input  logic [DATA_W-1:0] data_rdata
);

   bridge_state_e     state_q, state_d;
   logic              wr_q, wr_d;
   logic [1:0]        size_q, size_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic              capture;   // latch bus fields on IDLE -> ADDR
   logic              complete;  // bus transaction finishes this cycle
   logic [1:0]        wen_size;

   dmem_sram_like_bridge_wen_to_size u_wen_to_size (
      .wen_i  (cpu_wen),
      .size_o (wen_size)
   );

   always_comb begin
      state_d   = state_q;
      mem_stall = 1'b0;
      data_req  = 1'b0;
      capture   = 1'b0;
      complete  = 1'b0;

      unique case (state_q)
         StIdle: begin
            // Stall in the same cycle so the pipeline never runs past an
            // access that has not been issued yet.
            if (cpu_mem_en) begin
               mem_stall = 1'b1;
               capture   = 1'b1;
               state_d   = StAddr;
            end
         end
         StAddr: begin
            data_req  = 1'b1;
            mem_stall = 1'b1;
            if (data_addr_ok) begin
               if (data_data_ok) complete = 1'b1;
               else              state_d  = StData;
            end
         end
         StData: begin
            mem_stall = 1'b1;
            if (data_data_ok) complete = 1'b1;
         end
         StDone: begin
            if (!cpu_longest_stall) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase

      if (complete) begin
`ifdef DMEM_BRIDGE_RDATA_BYPASS_EN
         mem_stall = 1'b0;
         state_d   = cpu_longest_stall ? StDone : StIdle;
`else
         state_d   = StDone;
`endif
      end
   end

   always_comb begin
      wr_d    = wr_q;
      size_d  = size_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      if (capture) begin
         wr_d    = |cpu_wen;
         size_d  = (|cpu_wen) ? wen_size : cpu_size;
         addr_d  = cpu_addr;
         wdata_d = cpu_wdata;
      end
      if (complete) rdata_d = data_rdata;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= StIdle;
         wr_q    <= 1'b0;
         size_q  <= 2'd0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         size_q  <= size_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // Bus fields come from registers so they stay put while data_req is high.
   assign data_wr    = wr_q;
   assign data_size  = size_q;
   assign data_addr  = addr_q;
   assign data_wdata = wdata_q;

   always_comb begin
      cpu_rdata = rdata_q;
`ifdef DMEM_BRIDGE_RDATA_BYPASS_EN
      if (complete) cpu_rdata = data_rdata;
`endif
   end

endmodule

// File: tb/tb_dmem_sram_like_bridge.sv
module tb_dmem_sram_like_bridge;

`ifdef DMEM_BRIDGE_RDATA_BYPASS_EN
   localparam bit Bypass = 1'b1;
`else
   localparam bit Bypass = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        resetn;
   logic        cpu_mem_en;
   logic [3:0]  cpu_wen;
   logic [1:0]  cpu_size;
   logic [31:0] cpu_addr;
   logic [31:0] cpu_wdata;
   logic [31:0] cpu_rdata;
   logic        cpu_longest_stall;
   logic        mem_stall;
   logic        data_req;
   logic        data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr;
   logic [31:0] data_wdata;
   logic        data_addr_ok;
   logic        data_data_ok;
   logic [31:0] data_rdata;
   logic        ext_stall;

   int checks = 0;
   int errors = 0;
   logic [31:0] last_rdata;

   always #5 clk = ~clk;

   // The hazard unit ORs our own stall with the rest of the pipeline.
   assign cpu_longest_stall = mem_stall | ext_stall;

   dmem_sram_like_bridge #(.ADDR_W(32), .DATA_W(32)) dut (
      .clk               (clk),
      .resetn            (resetn),
      .cpu_mem_en        (cpu_mem_en),
      .cpu_wen           (cpu_wen),
      .cpu_size          (cpu_size),
      .cpu_addr          (cpu_addr),
      .cpu_wdata         (cpu_wdata),
      .cpu_rdata         (cpu_rdata),
      .cpu_longest_stall (cpu_longest_stall),
      .mem_stall         (mem_stall),
      .data_req          (data_req),
      .data_wr           (data_wr),
      .data_size         (data_size),
      .data_addr         (data_addr),
      .data_wdata        (data_wdata),
      .data_addr_ok      (data_addr_ok),
      .data_data_ok      (data_data_ok),
      .data_rdata        (data_rdata)
   );

   typedef struct {
      logic [3:0]  wen;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [1:0]  exp_size;
   } vec_t;

   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Bus size from the access rules: reads use cpu_size, stores use the
   // number of enabled byte lanes.
   function automatic logic [1:0] ref_size(input logic [3:0] wen, input logic [1:0] size);
      if (wen == 4'd0) return size;
      case ($countones(wen))
         4:       return 2'd2;
         2:       return 2'd1;
         default: return 2'd0;
      endcase
   endfunction

   function automatic logic [3:0] rand_wen();
      logic [3:0] tbl [10];
      tbl = '{4'h0, 4'h0, 4'h0, 4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF};
      return tbl[$urandom_range(0, 9)];
   endfunction

   // One access: addr_ok after a extra ADDR cycles, data_ok d cycles after
   // addr_ok (0 = same cycle), then s cycles of external pipeline stall.
   task automatic run_txn(input int a, input int d, input int s,
                          input logic [3:0] wen, input logic [1:0] size,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input logic [1:0] exp_sz);
      int c;
      int r0;
      int last;
      c    = a + 1 + d;             // cycle index of the completing data_ok
      r0   = Bypass ? c : c + 1;    // first cycle the access can retire
      last = r0 + s;                // retire cycle
      for (int k = 0; k <= last; k++) begin
         @(posedge clk); #1;
         cpu_mem_en = 1'b1;
         if (k == 0) begin
            cpu_wen = wen; cpu_size = size; cpu_addr = addr; cpu_wdata = wdata;
         end else begin
            cpu_wen   = rand_wen();
            cpu_size  = 2'($urandom_range(0, 2));
            cpu_addr  = $urandom;
            cpu_wdata = $urandom;
         end
         data_addr_ok = (k == a + 1);
         data_data_ok = (k == c) || (k >= 1 && k <= a && $urandom_range(0, 2) == 0)
                        || (k > c && $urandom_range(0, 2) == 0);
         data_rdata   = (k == c) ? rdata : $urandom;
         ext_stall    = (k >= r0 && k < last);
         @(negedge clk);
         chk("mem_stall", {31'd0, mem_stall}, {31'd0, (k < c) || (k == c && !Bypass)});
         chk("data_req", {31'd0, data_req}, {31'd0, (k >= 1 && k <= a + 1)});
         if (k >= 1 && k <= a + 1) begin
            chk("data_wr", {31'd0, data_wr}, {31'd0, wen != 4'd0});
            chk("data_size", {30'd0, data_size}, {30'd0, exp_sz});
            chk("data_addr", data_addr, addr);
            chk("data_wdata", data_wdata, wdata);
         end
         if (k >= r0) chk("cpu_rdata", cpu_rdata, rdata);
      end
      last_rdata = rdata;
   endtask

   // Idle cycles with stray bus responses that must be ignored.
   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk); #1;
         cpu_mem_en   = 1'b0;
         cpu_wen      = rand_wen();
         cpu_addr     = $urandom;
         data_addr_ok = 1'b0;
         data_data_ok = ($urandom_range(0, 1) == 0);
         data_rdata   = $urandom;
         ext_stall    = ($urandom_range(0, 1) == 0);
         @(negedge clk);
         chk("idle_stall", {31'd0, mem_stall}, 32'd0);
         chk("idle_req", {31'd0, data_req}, 32'd0);
         chk("idle_rdata", cpu_rdata, last_rdata);
      end
   endtask

   initial begin
      vecs[0] = '{4'h0, 2'd2, 32'h1000_0004, 32'h0,         32'hDEAD_BEEF, 2'd2};
      vecs[1] = '{4'h0, 2'd1, 32'h1000_0012, 32'h0,         32'h0000_8001, 2'd1};
      vecs[2] = '{4'h0, 2'd0, 32'h1000_0023, 32'h0,         32'h0000_007F, 2'd0};
      vecs[3] = '{4'h4, 2'd2, 32'h2000_0002, 32'h00AB_0000, 32'h1111_2222, 2'd0};
      vecs[4] = '{4'hF, 2'd0, 32'h2000_0010, 32'hCAFE_F00D, 32'h3333_4444, 2'd2};
      vecs[5] = '{4'h3, 2'd2, 32'h2000_0020, 32'h0000_BEEF, 32'h5555_6666, 2'd1};
      vecs[6] = '{4'hC, 2'd0, 32'h2000_0032, 32'hBEEF_0000, 32'h7777_8888, 2'd1};
      vecs[7] = '{4'h1, 2'd2, 32'h2000_0040, 32'h0000_00AA, 32'h9999_AAAA, 2'd0};
      vecs[8] = '{4'h2, 2'd1, 32'h2000_0051, 32'h0000_BB00, 32'hBBBB_CCCC, 2'd0};
      vecs[9] = '{4'h8, 2'd0, 32'h2000_0063, 32'hCC00_0000, 32'hDDDD_EEEE, 2'd0};

      resetn = 1'b0; cpu_mem_en = 1'b0; cpu_wen = 4'd0; cpu_size = 2'd0;
      cpu_addr = '0; cpu_wdata = '0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
      data_rdata = '0; ext_stall = 1'b0; last_rdata = '0;

      @(negedge clk);
      chk("rst_req", {31'd0, data_req}, 32'd0);
      chk("rst_stall", {31'd0, mem_stall}, 32'd0);
      chk("rst_rdata", cpu_rdata, 32'd0);
      @(posedge clk); #1 resetn = 1'b1;
      idle(2);

      // Size/write decode and the single-request read/store cases.
      for (int i = 0; i < 10; i++) begin
         run_txn(0, 1, 0, vecs[i].wen, vecs[i].size, vecs[i].addr, vecs[i].wdata,
                 vecs[i].rdata, vecs[i].exp_size);
         idle(1);
      end

      // Long pipeline stall after a load completes.
      run_txn(0, 1, 5, 4'h0, 2'd2, 32'h1000_0100, 32'h0, 32'h0BAD_F00D, 2'd2);
      // addr_ok delayed while cpu_* inputs wander.
      run_txn(4, 1, 0, 4'h0, 2'd1, 32'h1000_0200, 32'h0, 32'h0000_1234, 2'd1);
      // Same-cycle addr_ok and data_ok.
      run_txn(1, 0, 0, 4'h0, 2'd2, 32'h1000_0300, 32'h0, 32'h5A5A_A5A5, 2'd2);
      run_txn(0, 0, 2, 4'hF, 2'd0, 32'h1000_0304, 32'h1234_5678, 32'h0F0F_0F0F, 2'd2);
      idle(2);

      for (int i = 0; i < 150; i++) begin
         logic [3:0]  w;
         logic [1:0]  sz;
         w  = rand_wen();
         sz = 2'($urandom_range(0, 2));
         run_txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 w, sz, $urandom, $urandom, $urandom, ref_size(w, sz));
         if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
      end

      // Reset while waiting in DATA, then a stray data_ok.
      @(posedge clk); #1;
      cpu_mem_en = 1'b1; cpu_wen = 4'h0; cpu_size = 2'd2; cpu_addr = 32'h1000_0400;
      data_addr_ok = 1'b0; data_data_ok = 1'b0; ext_stall = 1'b0;
      @(posedge clk); #1 data_addr_ok = 1'b1;
      @(posedge clk); #1 data_addr_ok = 1'b0;
      @(negedge clk);
      chk("in_data_stall", {31'd0, mem_stall}, 32'd1);
      #2 resetn = 1'b0; cpu_mem_en = 1'b0;
      #1;
      chk("mid_rst_stall", {31'd0, mem_stall}, 32'd0);
      chk("mid_rst_req", {31'd0, data_req}, 32'd0);
      chk("mid_rst_wr", {31'd0, data_wr}, 32'd0);
      chk("mid_rst_size", {30'd0, data_size}, 32'd0);
      chk("mid_rst_addr", data_addr, 32'd0);
      chk("mid_rst_rdata", cpu_rdata, 32'd0);
      @(posedge clk); #1 resetn = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         data_data_ok = 1'b1; data_rdata = 32'hCAFE_F00D;
         @(negedge clk);
         chk("stray_ok_stall", {31'd0, mem_stall}, 32'd0);
         chk("stray_ok_req", {31'd0, data_req}, 32'd0);
         chk("stray_ok_rdata", cpu_rdata, 32'd0);
      end
      last_rdata = '0;
      idle(1);
      run_txn(0, 1, 1, 4'h0, 2'd2, 32'h1000_0500, 32'h0, 32'hFACE_B00C, 2'd2);
      idle(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
